// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode/imm_src constants and the decoded bundle type
// Contents: OP_* opcode codes, IMM_* immediate-select codes, decoded_t bundle
package decode_pkg;
  localparam logic [1:0] OP_DP = 2'd0;
  localparam logic [1:0] OP_MEM = 2'd1;
  localparam logic [1:0] OP_BR = 2'd2;
  localparam logic [1:0] OP_UND = 2'd3;
  localparam logic [1:0] IMM_DP8 = 2'd0;
  localparam logic [1:0] IMM_MEM12 = 2'd1;
  localparam logic [1:0] IMM_BR24 = 2'd2;
  localparam logic [1:0] IMM_UND = 2'd3;
  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
    logic [1:0] imm_src;
    logic [23:0] imm;
    logic reg_write;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic illegal;
  } decoded_t;
endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: combinational decode of a 32-bit instruction into decoded_t
// Ports: instr (in, 32) instruction word; dec (out, decoded_t) decoded fields and controls
// Build option: DECODE_ILLEGAL_TRAP_EN flags op=11 as illegal with imm_src=3, else op=11 is a NOP
module instr_field_decode
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic [1:0] UND_SRC = IMM_UND;
  localparam logic UND_ILL = 1'b1;
`else
  localparam logic [1:0] UND_SRC = IMM_DP8;
  localparam logic UND_ILL = 1'b0;
`endif
  logic [1:0] op;
  logic [5:0] funct;
  assign op = instr[27:26];
  assign funct = instr[25:20];
  always_comb begin
    dec.cond = instr[31:28];
    dec.op = op;
    dec.funct = funct;
    dec.rn = instr[19:16];
    dec.rd = instr[15:12];
    dec.rm = instr[3:0];
    dec.imm = instr[23:0];
    dec.imm_src = op == OP_DP ? IMM_DP8 : op == OP_MEM ? IMM_MEM12 : op == OP_BR ? IMM_BR24 : UND_SRC;
    dec.reg_write = op == OP_DP ? funct[4:3] != 2'b10 : op == OP_MEM ? funct[0] : op == OP_BR && instr[24];
    dec.mem_write = op == OP_MEM && !funct[0];
    dec.alu_src = op == OP_DP ? funct[5] : op != OP_UND;
    dec.branch = op == OP_BR;
    dec.illegal = op == OP_UND && UND_ILL;
  end
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: decode stage with registered output and one skid entry, flushable
// Ports: clk, rst (async high), flush; in_valid/in_ready/in_instr/in_pc fetch side;
//        out_valid/out_ready plus out_pc, out_cond, out_op, out_funct, out_rn, out_rd, out_rm,
//        out_imm_src, out_imm, out_reg_write, out_mem_write, out_alu_src, out_branch, out_illegal
// Build option: DECODE_ILLEGAL_TRAP_EN (see instr_field_decode)
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]      out_cond,
  output logic [1:0]      out_op,
  output logic [5:0]      out_funct,
  output logic [3:0]      out_rn,
  output logic [3:0]      out_rd,
  output logic [3:0]      out_rm,
  output logic [1:0]      out_imm_src,
  output logic [23:0]     out_imm,
  output logic            out_reg_write,
  output logic            out_mem_write,
  output logic            out_alu_src,
  output logic            out_branch,
  output logic            out_illegal
);
  decoded_t dec, out_q, skid_q;
  logic [PC_W-1:0] skid_pc;
  logic skid_valid;
  instr_field_decode u_dec (.instr(in_instr), .dec(dec));
  // in_ready mirrors !skid_valid, so outside the skid branch every in_valid is a transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready <= 1'b1;
      out_q <= '0;
      skid_q <= '0;
      out_pc <= '0;
      skid_pc <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready <= 1'b1;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_q <= skid_q;
        out_pc <= skid_pc;
        skid_valid <= 1'b0;
        in_ready <= 1'b1;
      end
    end else if (!out_valid || out_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= dec;
        out_pc <= in_pc;
      end
    end else if (in_valid) begin
      skid_q <= dec;
      skid_pc <= in_pc;
      skid_valid <= 1'b1;
      in_ready <= 1'b0;
    end
  end
  assign out_cond = out_q.cond;
  assign out_op = out_q.op;
  assign out_funct = out_q.funct;
  assign out_rn = out_q.rn;
  assign out_rd = out_q.rd;
  assign out_rm = out_q.rm;
  assign out_imm_src = out_q.imm_src;
  assign out_imm = out_q.imm;
  assign out_reg_write = out_q.reg_write;
  assign out_mem_write = out_q.mem_write;
  assign out_alu_src = out_q.alu_src;
  assign out_branch = out_q.branch;
  assign out_illegal = out_q.illegal;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: scoreboard bench for instr_decode_stage
module tb_instr_decode_stage;
  localparam int PC_W = 32;
  localparam int W = PC_W + 55;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [31:0] in_instr = 0;
  logic [PC_W-1:0] in_pc = 0, out_pc;
  logic [3:0] out_cond, out_rn, out_rd, out_rm;
  logic [1:0] out_op, out_imm_src;
  logic [5:0] out_funct;
  logic [23:0] out_imm;
  logic out_reg_write, out_mem_write, out_alu_src, out_branch, out_illegal;
  logic [W-1:0] act;
  logic [W-1:0] q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  instr_decode_stage #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_cond(out_cond), .out_op(out_op), .out_funct(out_funct),
    .out_rn(out_rn), .out_rd(out_rd), .out_rm(out_rm), .out_imm_src(out_imm_src),
    .out_imm(out_imm), .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
    .out_alu_src(out_alu_src), .out_branch(out_branch), .out_illegal(out_illegal)
  );
  assign act = {out_pc, out_cond, out_op, out_funct, out_rn, out_rd, out_rm, out_imm_src, out_imm,
                out_reg_write, out_mem_write, out_alu_src, out_branch, out_illegal};
  function automatic logic [W-1:0] model(logic [31:0] i, logic [PC_W-1:0] pc);
    logic [1:0] is;
    logic rw, mw, as, br, il;
    rw = 0; mw = 0; as = 0; br = 0; il = 0; is = 0;
    case (i[27:26])
      2'b00: begin is = 0; as = i[25]; rw = !(i[24] && !i[23]); end
      2'b01: begin is = 1; as = 1; mw = !i[20]; rw = i[20]; end
      2'b10: begin is = 2; as = 1; br = 1; rw = i[24]; end
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        is = 3; il = 1;
`endif
      end
    endcase
    return {pc, i[31:28], i[27:26], i[25:20], i[19:16], i[15:12], i[3:0], is, i[23:0], rw, mw, as, br, il};
  endfunction
  // Inputs change only just after posedge, so the negedge sees exactly what the next edge will transfer.
  always @(negedge clk or posedge rst) begin
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready && !flush) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got=%h required=none", act);
        end else begin
          if (act !== q[0]) begin
            errors++;
            $display("FAIL sb_bundle got=%h required=%h", act, q[0]);
          end
          void'(q.pop_front());
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #1 rst = 1;
    #1;
    checks++; if (out_valid !== 0 || in_ready !== 1 || act !== '0) begin errors++; $display("FAIL reset_init got v=%b r=%b d=%h required v=0 r=1 d=0", out_valid, in_ready, act); end
    tick; rst = 0; tick;
    out_ready = 0; in_valid = 1; in_instr = 32'hE2821005; in_pc = 32'h100;
    tick; in_valid = 0;
    checks++; if (out_valid !== 1) begin errors++; $display("FAIL reset_pre got v=%b required 1", out_valid); end
    #2 rst = 1;
    #1;
    checks++; if (out_valid !== 0 || in_ready !== 1 || act !== '0) begin errors++; $display("FAIL reset_mid got v=%b r=%b d=%h required v=0 r=1 d=0", out_valid, in_ready, act); end
    tick; rst = 0; tick;
  endtask
  task automatic test_dp;
    out_ready = 1; in_valid = 1; in_instr = 32'hE2821005; in_pc = 32'h200;
    tick; in_valid = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1 || out_imm_src !== 2'd0 || out_imm !== 24'h821005 || out_rn !== 4'd2 || out_rd !== 4'd1 ||
        out_alu_src !== 1 || out_reg_write !== 1 || out_funct !== 6'h28) begin
      errors++; $display("FAIL dp_fields got v=%b is=%0d imm=%h rn=%0d rd=%0d as=%b rw=%b f=%h", out_valid, out_imm_src, out_imm, out_rn, out_rd, out_alu_src, out_reg_write, out_funct);
    end
    tick;
  endtask
  task automatic test_mem;
    out_ready = 1; in_valid = 1; in_instr = 32'hE5943008; in_pc = 32'h300;
    tick; in_instr = 32'hE5843008; in_pc = 32'h304;
    @(negedge clk);
    checks++; if (out_imm_src !== 2'd1 || out_reg_write !== 1 || out_mem_write !== 0) begin errors++; $display("FAIL ldr got is=%0d rw=%b mw=%b required 1 1 0", out_imm_src, out_reg_write, out_mem_write); end
    tick; in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1 || out_mem_write !== 1 || out_reg_write !== 0) begin errors++; $display("FAIL str got v=%b mw=%b rw=%b required 1 1 0", out_valid, out_mem_write, out_reg_write); end
    tick;
  endtask
  task automatic test_branch;
    out_ready = 1; in_valid = 1; in_instr = 32'hEA000010; in_pc = 32'h400;
    tick; in_instr = 32'hEB000010; in_pc = 32'h404;
    @(negedge clk);
    checks++; if (out_imm_src !== 2'd2 || out_imm !== 24'h000010 || out_branch !== 1 || out_reg_write !== 0) begin errors++; $display("FAIL b got is=%0d imm=%h br=%b rw=%b", out_imm_src, out_imm, out_branch, out_reg_write); end
    tick; in_valid = 0;
    @(negedge clk);
    checks++; if (out_branch !== 1 || out_reg_write !== 1) begin errors++; $display("FAIL bl got br=%b rw=%b required 1 1", out_branch, out_reg_write); end
    tick;
  endtask
  task automatic test_backpressure;
    out_ready = 0; in_valid = 1; in_instr = 32'hE0812003; in_pc = 32'h500;
    tick; in_instr = 32'hE5912004; in_pc = 32'h504;
    tick; in_instr = 32'hE3A00001; in_pc = 32'h508;
    @(negedge clk);
    checks++; if (in_ready !== 0 || out_valid !== 1) begin errors++; $display("FAIL bp_full got r=%b v=%b required 0 1", in_ready, out_valid); end
    tick; tick;
    checks++; if (out_pc !== 32'h500) begin errors++; $display("FAIL bp_stable got pc=%h required 500", out_pc); end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    checks++; if (in_ready !== 0) begin errors++; $display("FAIL bp_hold got r=%b required 0", in_ready); end
    tick;
    @(negedge clk);
    checks++; if (in_ready !== 1 || out_valid !== 1) begin errors++; $display("FAIL bp_drain got r=%b v=%b required 1 1", in_ready, out_valid); end
    tick;
    @(negedge clk);
    checks++; if (out_valid !== 0 || q.size() != 0) begin errors++; $display("FAIL bp_empty got v=%b q=%0d required 0 0", out_valid, q.size()); end
  endtask
  task automatic test_flush;
    tick;
    out_ready = 0; in_valid = 1; in_instr = 32'hE0800001; in_pc = 32'h600;
    tick; in_instr = 32'hE0800002; in_pc = 32'h604;
    tick; in_instr = 32'hE0800003; in_pc = 32'h608; flush = 1;
    tick; flush = 0; in_valid = 0;
    checks++; if (out_valid !== 0 || in_ready !== 1) begin errors++; $display("FAIL flush_full got v=%b r=%b required 0 1", out_valid, in_ready); end
    in_valid = 1; in_instr = 32'hE0800004; in_pc = 32'h60C; flush = 1;
    tick; flush = 0; in_valid = 0;
    checks++; if (out_valid !== 0) begin errors++; $display("FAIL flush_in got v=%b required 0", out_valid); end
    out_ready = 1;
    tick; tick;
    checks++; if (out_valid !== 0 || q.size() != 0) begin errors++; $display("FAIL flush_after got v=%b q=%0d required 0 0", out_valid, q.size()); end
  endtask
  task automatic test_illegal;
    out_ready = 1; in_valid = 1; in_instr = 32'hEC000000; in_pc = 32'h700;
    tick; in_valid = 0;
    @(negedge clk);
    checks++;
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (out_illegal !== 1 || out_imm_src !== 2'd3 || out_reg_write !== 0 || out_mem_write !== 0 || out_branch !== 0) begin
      errors++; $display("FAIL illegal got il=%b is=%0d required 1 3", out_illegal, out_imm_src);
    end
`else
    if (out_illegal !== 0 || out_imm_src !== 2'd0 || out_reg_write !== 0 || out_mem_write !== 0 || out_branch !== 0) begin
      errors++; $display("FAIL nop got il=%b is=%0d rw=%b required 0 0 0", out_illegal, out_imm_src, out_reg_write);
    end
`endif
    tick;
  endtask
  task automatic test_back_to_back;
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; in_instr = $urandom; in_pc = 32'h800 + 4 * k;
      @(negedge clk);
      checks++; if (in_ready !== 1 || (k > 0 && out_valid !== 1)) begin errors++; $display("FAIL b2b_%0d got r=%b v=%b", k, in_ready, out_valid); end
      tick;
    end
    in_valid = 0;
    tick;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_left got %0d required 0", q.size()); end
  endtask
  task automatic test_random;
    for (int k = 0; k < 400; k++) begin
      in_valid = $urandom_range(0, 1); out_ready = $urandom_range(0, 3) != 0;
      in_instr = $urandom; in_pc = $urandom;
      flush = $urandom_range(0, 31) == 0;
      tick;
    end
    in_valid = 0; out_ready = 1; flush = 0;
    for (int k = 0; k < 10 && q.size() != 0; k++) tick;
    tick;
    checks++; if (q.size() != 0 || out_valid !== 0) begin errors++; $display("FAIL rand_drain got q=%0d v=%b required 0 0", q.size(), out_valid); end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_dp;
    test_mem;
    test_branch;
    test_backpressure;
    test_flush;
    test_illegal;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Decode stage of the processor datapath; it produces the immediate-select code and raw 24-bit immediate field that the immediate extender consumes.
- Accepts fetched 32-bit ARM-style instructions over a valid/ready handshake.
- Decodes condition, opcode, register fields, control signals, imm_src and imm.
- Registers the results behind a 2-entry skid buffer (1-cycle latency, full throughput), with flush for taken branches.

Parameters:
- PC_W, 32, width of the carried program counter.

Ports:
- clk  in  1  clock (all state on rising edge)
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all buffered instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode can accept; registered, equals !skid_valid
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  PC_W  carried PC
- out_cond  out  4  instr[31:28]
- out_op  out  2  instr[27:26]
- out_funct  out  6  instr[25:20]
- out_rn, out_rd, out_rm  out  4 each  instr[19:16], instr[15:12], instr[3:0]
- out_imm_src  out  2  0=imm8 (data-proc), 1=imm12 (memory), 2=imm24 branch (extender scales by 4)
- out_imm  out  24  instr[23:0], unmodified
- out_reg_write, out_mem_write, out_alu_src, out_branch  out  1 each  control
- out_illegal  out  1  undefined opcode flag

Behaviour:
- Reset (async, any time): out_valid=0, skid_valid=0, in_ready=1, all other outputs 0.
- Decode rules by op:
  - op=00: imm_src=0; alu_src=funct[5]; mem_write=0; branch=0; reg_write=0 if funct[4:3]==2'b10 (TST/TEQ/CMP/CMN), else 1.
  - op=01: imm_src=1; alu_src=1; mem_write=!funct[0]; reg_write=funct[0]; branch=0.
  - op=10: imm_src=2; alu_src=1; branch=1; reg_write=instr[24] (link); mem_write=0.
  - op=11: see Optional Feature.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Latency: an instruction accepted in cycle N is presented on out_* in cycle N+1 if the output register is free or draining.
- Skid: if an input transfer occurs while out_valid=1 and out_ready=0, the decoded bundle goes to the skid entry; skid_valid=1 and in_ready=0 next cycle.
- Drain: on an output transfer with skid_valid=1, skid moves to the output register; skid_valid=0 and in_ready=1 next cycle.
- Simultaneous input and output transfers with an empty skid: the output register loads the new bundle and out_valid stays 1.
- Bundles stay stable while out_valid=1 and out_ready=0. Order is strictly FIFO; no drops or duplicates.
- Flush: next cycle out_valid=0, skid_valid=0, in_ready=1. An input transfer in the flush cycle is discarded. Flush has priority over all transfers.
- Decode is purely combinational on in_instr; only the registered bundles are visible.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined: op=11 sets out_illegal=1 and forces reg_write, mem_write and branch to 0; imm_src=3.
- Undefined: out_illegal tied 0; op=11 decodes as a NOP (all write enables 0, imm_src=0).

Decomposition:
- Package decode_pkg holds:
  - imm_src constants IMM_DP8=2'd0, IMM_MEM12=2'd1, IMM_BR24=2'd2;
  - op constants OP_DP, OP_MEM, OP_BR, OP_UND;
  - packed struct decoded_t bundling all out_* fields.
- Sub-module instr_field_decode: combinational in_instr -> decoded_t. The top holds the output and skid registers.

Test Plan:
- Reset mid-stream with out_valid=1 -> out_valid=0, in_ready=1, outputs 0 immediately.
- 0xE2821005 with out_ready=1 -> next cycle imm_src=0, imm=0x821005, rn=2, rd=1, alu_src=1, reg_write=1, funct=0x28.
- 0xE5943008 then 0xE5843008 back-to-back -> LDR: imm_src=1, reg_write=1, mem_write=0; STR: mem_write=1, reg_write=0.
- 0xEA000010 -> imm_src=2, imm=0x000010, branch=1, reg_write=0. 0xEB000010 -> reg_write=1.
- Backpressure: hold out_ready=0 and send 3 instructions -> 2 accepted, in_ready=0 after the second. Release -> delivered in order; in_ready returns 1 after the skid drains.
- Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, the flush-cycle instruction never appears. With macro defined, 0xEC000000 -> out_illegal=1, imm_src=3.
